// File: rtl/zrb_uart_rx.sv
// UART receiver: 8x oversampled start/data/stop framing that writes each good frame
// into a downstream FIFO on wr_clk, with sticky frame-error and overrun flags.
module zrb_uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 wr_clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 fifo_full,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [2:0]           r_os_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_wr_en;
  logic                 r_frame_err;
  logic                 r_overrun;

  state_t               w_state_nxt;
  logic [2:0]           w_os_cnt_nxt;
  logic [2:0]           w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_load;
  logic                 w_wr;
  logic                 w_set_ferr;
  logic                 w_set_ovr;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_os_cnt_nxt  = r_os_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_load        = 1'b0;
    w_wr          = 1'b0;
    w_set_ferr    = 1'b0;
    w_set_ovr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt  = S_START;
          w_os_cnt_nxt = 3'd0;
        end
      end
      S_START: begin
        if (os_tick) begin
          if (r_os_cnt == 3'd3) begin
            if (!r_rx_s) begin
              w_state_nxt   = S_DATA;
              w_os_cnt_nxt  = 3'd0;
              w_bit_cnt_nxt = 3'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_os_cnt_nxt = r_os_cnt + 3'd1;
          end
        end
      end
      S_DATA: begin
        if (os_tick) begin
          w_os_cnt_nxt = r_os_cnt + 3'd1;
          if (r_os_cnt == 3'd7) begin
            w_shift_nxt   = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (os_tick) begin
          w_os_cnt_nxt = r_os_cnt + 3'd1;
          if (r_os_cnt == 3'd7) begin
            if (r_rx_s) begin
              w_load      = 1'b1;
              w_wr        = !fifo_full;
              w_set_ovr   = fifo_full;
              w_state_nxt = S_IDLE;
            end else begin
              w_set_ferr  = 1'b1;
              w_state_nxt = S_BRK;
            end
          end
        end
      end
      // A held-low line parks here so it cannot retrigger a stream of frames.
      S_BRK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_os_cnt    <= 3'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_os_cnt    <= w_os_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_wr_en     <= w_wr;
      if (w_load) r_data_out <= r_shift;
      // A set event in the same cycle as err_clr takes priority.
      r_frame_err <= w_set_ferr | (r_frame_err & ~err_clr);
      r_overrun   <= w_set_ovr  | (r_overrun   & ~err_clr);
    end
  end

  assign data_out    = r_data_out;
  assign wr_en       = r_wr_en;
  assign busy        = (r_state != S_IDLE);
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_zrb_uart_rx.sv
// Self-checking bench for zrb_uart_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_zrb_uart_rx;

  logic       wr_clk = 1'b0;
  logic       reset = 1'b1;
  logic       os_tick = 1'b0;
  logic       rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       wr_en;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_last = 8'h00;
  int         wr_cnt = 0;
  bit         wr_double = 0;
  bit         wr_while_full = 0;
  bit         ovr_seen = 0;
  bit         prev_wr = 0;
  bit         jitter = 0;
  int         tick_cnt = 0;
  int         cur_period = 4;

  zrb_uart_rx #(.DATA_BITS(8)) dut (
    .wr_clk      (wr_clk),
    .reset       (reset),
    .os_tick     (os_tick),
    .rx          (rx),
    .fifo_full   (fifo_full),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .wr_en       (wr_en),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  // Clock / tick generation
  always #5 wr_clk = ~wr_clk;

  always begin
    @(posedge wr_clk);
    #1;
    if (tick_cnt >= cur_period - 1) begin
      os_tick    = 1'b1;
      tick_cnt   = 0;
      cur_period = jitter ? int'($urandom_range(6, 2)) : 4;
    end else begin
      os_tick  = 1'b0;
      tick_cnt = tick_cnt + 1;
    end
  end

  // Write monitor feeding the scoreboard
  always @(negedge wr_clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back(data_out);
      wr_cnt = wr_cnt + 1;
      if (prev_wr) wr_double = 1;
      if (fifo_full) wr_while_full = 1;
    end
    prev_wr = (wr_en === 1'b1);
    if (overrun === 1'b1) ovr_seen = 1;
  end

  // Driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wr_clk);
      while (os_tick !== 1'b1) @(posedge wr_clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_ticks(8);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(8);
    end
    rx = stop;
    wait_ticks(8);
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    wr_cnt = 0;
    wr_double = 0;
    wr_while_full = 0;
    ovr_seen = 0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge wr_clk);
    #2;
    err_clr = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    repeat (3) @(posedge wr_clk);
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h exp 00", data_out); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b exp 0", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b exp 00", frame_err, overrun); end
    #1;
    reset = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    clear_mon();
    exp_q.push_back(8'hA5);
    exp_last = 8'hA5;
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    checks++; if (wr_cnt !== exp_q.size()) begin errors++; $display("FAIL basic_wr_count: got %0d exp %0d", wr_cnt, exp_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL basic_wr_data: got %h exp %h", (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_out: got %h exp a5", data_out); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL basic_flags: got %b%b exp 00", frame_err, overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b exp 0", busy); end
  endtask

  task automatic test_false_start();
    clear_mon();
    rx = 1'b0;
    wait_ticks(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_hi: got %b exp 1", busy); end
    rx = 1'b1;
    wait_ticks(12);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL false_start_wr: got %0d exp 0", wr_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_lo: got %b exp 0", busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL false_start_flags: got %b%b exp 00", frame_err, overrun); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    wait_ticks(30);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b exp 1", frame_err); end
    checks++; if (data_out !== exp_last) begin errors++; $display("FAIL ferr_data_kept: got %h exp %h", data_out, exp_last); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL ferr_wr: got %0d exp 0", wr_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_hold: got %b exp 1", busy); end
    rx = 1'b1;
    wait_ticks(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit: got %b exp 0", busy); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b exp 1", frame_err); end
    pulse_err_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b exp 0", frame_err); end
  endtask

  task automatic test_overrun();
    clear_mon();
    fifo_full = 1'b1;
    exp_last = 8'h55;
    send_frame(8'h55, 1'b1);
    wait_ticks(4);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL ovr_wr: got %0d exp 0", wr_cnt); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL ovr_data_out: got %h exp 55", data_out); end
    checks++; if (overrun !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL ovr_flags: got %b%b exp 01", frame_err, overrun); end
    fifo_full = 1'b0;
    pulse_err_clr();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
  endtask

  task automatic test_set_wins();
    clear_mon();
    fifo_full = 1'b1;
    err_clr = 1'b1;
    exp_last = 8'h96;
    send_frame(8'h96, 1'b1);
    wait_ticks(4);
    err_clr = 1'b0;
    fifo_full = 1'b0;
    checks++; if (ovr_seen !== 1'b1) begin errors++; $display("FAIL set_wins_seen: got %b exp 1", ovr_seen); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL set_wins_cleared: got %b exp 0", overrun); end
    checks++; if (data_out !== 8'h96 || wr_cnt !== 0) begin errors++; $display("FAIL set_wins_data: got %h/%0d exp 96/0", data_out, wr_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hF0;
    clear_mon();
    rx = 1'b0;
    wait_ticks(8);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_ticks(8);
    end
    rx = b[4];
    wait_ticks(4);
    reset = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00 || wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_outs: got %h/%b exp 00/0", data_out, wr_en); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got %b%b%b exp 000", busy, frame_err, overrun); end
    repeat (3) @(posedge wr_clk);
    #2;
    rx = 1'b1;
    reset = 1'b0;
    wait_ticks(12);
    checks++; if (wr_cnt !== 0 || busy !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_abort: got wr=%0d busy=%b ferr=%b exp 0/0/0", wr_cnt, busy, frame_err); end
    exp_last = 8'h0F;
    send_frame(8'h0F, 1'b1);
    wait_ticks(4);
    checks++; if (wr_cnt !== 1 || got_q.size() < 1 || got_q[0] !== 8'h0F) begin errors++; $display("FAIL rst_mid_next: got wr=%0d data=%h exp 1/0f", wr_cnt, data_out); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_last = 8'hFF;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", wr_cnt); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (wr_double !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %b exp 0", wr_double); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit full, good, m_ferr, m_ovr;
    m_ferr = 0;
    m_ovr = 0;
    clear_mon();
    jitter = 1;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      full = ($urandom_range(3, 0) == 0);
      good = ($urandom_range(5, 0) != 0);
      fifo_full = full;
      send_frame(b, good);
      if (good) begin
        exp_last = b;
        if (full) m_ovr = 1;
        else exp_q.push_back(b);
      end else begin
        m_ferr = 1;
      end
      fifo_full = 1'b0;
      if (!good) begin
        rx = 1'b1;
        wait_ticks(int'($urandom_range(16, 8)));
      end else if ($urandom_range(1, 0) == 1) begin
        wait_ticks(int'($urandom_range(12, 1)));
      end
    end
    wait_ticks(4);
    jitter = 0;
    checks++; if (wr_cnt !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d exp %0d", wr_cnt, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (data_out !== exp_last) begin errors++; $display("FAIL rand_data_out: got %h exp %h", data_out, exp_last); end
    checks++; if (frame_err !== m_ferr || overrun !== m_ovr) begin errors++; $display("FAIL rand_flags: got %b%b exp %b%b", frame_err, overrun, m_ferr, m_ovr); end
    checks++; if (wr_double !== 1'b0 || wr_while_full !== 1'b0) begin errors++; $display("FAIL rand_wr_rules: got dbl=%b full=%b exp 0/0", wr_double, wr_while_full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy: got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_set_wins();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
